// File: rtl/tbird_switch_ctrl_pkg.sv
// Shared mode encoding and sizing helper for the T-bird switch front end.
package tbird_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tbird_switch_ctrl_if.sv
// Raw switch inputs and sequencer controls between the switch panel and the controller.
interface tbird_switch_ctrl_if;
    logic       RAW_HAZ;
    logic       RAW_LEFT;
    logic       RAW_RIGHT;
    logic       SW0;
    logic       SW1;
    logic       SW2;
    logic       STEP;
    logic [1:0] MODE;

    // Level signals, no handshake: raw switches flow in, registered controls flow out.
    modport master (
        output RAW_HAZ, RAW_LEFT, RAW_RIGHT,
        input  SW0, SW1, SW2, STEP, MODE
    );

    modport slave (
        input  RAW_HAZ, RAW_LEFT, RAW_RIGHT,
        output SW0, SW1, SW2, STEP, MODE
    );
endinterface

// File: rtl/tbird_switch_ctrl_sw_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw switch.
module sw_debounce
    import tbird_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb
);
    localparam int CW = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        // Any cycle of agreement restarts the count, so short glitches never flip deb.
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb = deb_q;
endmodule

// File: rtl/tbird_switch_ctrl.sv
// Debounces the driver switches, arbitrates one mode and updates sequencer
// controls only on step boundaries so the light pattern never changes mid-step.
module tbird_switch_ctrl
    import tbird_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int STEP_DIV   = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    tbird_switch_ctrl_if.slave bus
);
    localparam int PW = cnt_width(STEP_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);

    logic          deb_haz, deb_left, deb_right;
    logic [PW-1:0] pre_q, pre_d;
    logic          step;
    mode_e         req;
    mode_e         state_q, state_d;
    logic          sw0_q, sw0_d;
    logic          sw1_q, sw1_d;
    logic          sw2_q, sw2_d;

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_haz (
        .clk(CLK), .rst_n(RST_N), .raw(bus.RAW_HAZ), .deb(deb_haz)
    );
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
        .clk(CLK), .rst_n(RST_N), .raw(bus.RAW_LEFT), .deb(deb_left)
    );
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
        .clk(CLK), .rst_n(RST_N), .raw(bus.RAW_RIGHT), .deb(deb_right)
    );

    assign step  = (pre_q == PRE_LAST);
    assign pre_d = step ? '0 : pre_q + 1'b1;

    // Both turn switches at once are treated as a hazard request.
    always_comb begin
        req = MODE_IDLE;
        if (deb_haz || (deb_left && deb_right)) begin
            req = MODE_HAZARD;
        end else if (deb_left) begin
            req = MODE_LEFT;
        end else if (deb_right) begin
            req = MODE_RIGHT;
        end
    end

    always_comb begin
        state_d = state_q;
        sw0_d   = sw0_q;
        sw1_d   = sw1_q;
        sw2_d   = sw2_q;
        if (step) begin
            state_d = req;
            sw1_d   = (req == MODE_LEFT);
            sw2_d   = (req == MODE_RIGHT);
            // Hazard starts lit and then blinks once per step while it persists.
            if (req == MODE_HAZARD) begin
                sw0_d = (state_q == MODE_HAZARD) ? ~sw0_q : 1'b1;
            end else begin
                sw0_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pre_q   <= '0;
            state_q <= MODE_IDLE;
            sw0_q   <= 1'b0;
            sw1_q   <= 1'b0;
            sw2_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            state_q <= state_d;
            sw0_q   <= sw0_d;
            sw1_q   <= sw1_d;
            sw2_q   <= sw2_d;
        end
    end

    assign bus.SW0  = sw0_q;
    assign bus.SW1  = sw1_q;
    assign bus.SW2  = sw2_q;
    assign bus.STEP = step;
    assign bus.MODE = state_q;
endmodule

// File: tb/tb_tbird_switch_ctrl.sv
// Directed bench for tbird_switch_ctrl with DEB_CYCLES=4, STEP_DIV=4.
// Edge numbers in comments count rising edges after reset release; e4, e8, ... are step edges.
module tb_tbird_switch_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tbird_switch_ctrl_if bus ();

    tbird_switch_ctrl #(.DEB_CYCLES(4), .STEP_DIV(4)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] mode, input logic s0,
                           input logic s1, input logic s2);
        chk({tag, "_mode"}, bus.MODE, mode);
        chk({tag, "_sw0"}, {1'b0, bus.SW0}, {1'b0, s0});
        chk({tag, "_sw1"}, {1'b0, bus.SW1}, {1'b0, s1});
        chk({tag, "_sw2"}, {1'b0, bus.SW2}, {1'b0, s2});
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.RAW_HAZ   = 1'b0;
        bus.RAW_LEFT  = 1'b0;
        bus.RAW_RIGHT = 1'b0;

        edges(2);
        chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_step", {1'b0, bus.STEP}, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Prescaler phase, then left turn whose deb rises at e9, one cycle after step e8.
        edges(2);
        chk("pre_e2_step", {1'b0, bus.STEP}, 2'd0);
        edges(1);
        chk("pre_e3_step", {1'b0, bus.STEP}, 2'd1);
        bus.RAW_LEFT = 1'b1;
        edges(1);
        chk("pre_e4_step", {1'b0, bus.STEP}, 2'd0);
        chk("e4_mode", bus.MODE, 2'd0);
        edges(4);
        chk_all("e8_idle", 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 9; i <= 11; i++) begin
            edges(1);
            chk($sformatf("align_e%0d_sw1", i), {1'b0, bus.SW1}, 2'd0);
        end
        edges(1);
        chk_all("e12_left", 2'd1, 1'b0, 1'b1, 1'b0);

        // Release left: deb falls at e18, so LEFT holds at e16 and clears at e20.
        bus.RAW_LEFT = 1'b0;
        edges(4);
        chk("e16_mode", bus.MODE, 2'd1);
        edges(4);
        chk_all("e20_idle", 2'd0, 1'b0, 1'b0, 1'b0);

        // Right pulse of only 3 cycles must be rejected.
        bus.RAW_RIGHT = 1'b1;
        for (int i = 21; i <= 32; i++) begin
            edges(1);
            if (i == 23) bus.RAW_RIGHT = 1'b0;
            chk($sformatf("bounce_e%0d_sw2", i), {1'b0, bus.SW2}, 2'd0);
            chk($sformatf("bounce_e%0d_mode", i), bus.MODE, 2'd0);
        end

        // Held right: deb rises at e38, taken at step e40.
        bus.RAW_RIGHT = 1'b1;
        edges(7);
        chk("e39_sw2", {1'b0, bus.SW2}, 2'd0);
        edges(1);
        chk_all("e40_right", 2'd2, 1'b0, 1'b0, 1'b1);

        // Left plus right arbitrates to hazard at e48.
        bus.RAW_LEFT = 1'b1;
        edges(4);
        chk("e44_mode", bus.MODE, 2'd2);
        edges(4);
        chk_all("e48_haz", 2'd3, 1'b1, 1'b0, 1'b0);
        edges(4);
        chk_all("e52_haz", 2'd3, 1'b0, 1'b0, 1'b0);
        bus.RAW_RIGHT = 1'b0;
        edges(4);
        chk_all("e56_haz", 2'd3, 1'b1, 1'b0, 1'b0);
        edges(3);
        chk("e59_sw0", {1'b0, bus.SW0}, 2'd1);
        edges(1);
        chk_all("e60_left", 2'd1, 1'b0, 1'b1, 1'b0);

        // Hazard switch: deb haz rises / deb left falls at e66; blink from e68.
        bus.RAW_LEFT = 1'b0;
        bus.RAW_HAZ  = 1'b1;
        edges(4);
        chk("e64_mode", bus.MODE, 2'd1);
        for (int k = 0; k < 4; k++) begin
            edges(4);
            chk_all($sformatf("blink%0d", k), 2'd3, (k % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a step, away from any clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 2'd0, 1'b0, 1'b0, 1'b0);
        chk("async_rst_step", {1'b0, bus.STEP}, 2'd0);
        bus.RAW_HAZ = 1'b0;
        edges(2);
        chk("in_rst_step", {1'b0, bus.STEP}, 2'd0);
        chk("in_rst_mode", bus.MODE, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        edges(2);
        chk("rel_e2_step", {1'b0, bus.STEP}, 2'd0);
        edges(1);
        chk("rel_e3_step", {1'b0, bus.STEP}, 2'd1);
        edges(1);
        chk_all("rel_e4_idle", 2'd0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
